harpoon_bank: RTL and testbench

- Multi-slot harpoon (bullet) controller for one player; generalises the single-shot bullet block.
- Provides NUM_SHOTS independent harpoon slots, a fire edge detector, double-shot and sticky-harpoon modes with timed hold, and a per-slot hit interface.
- Sits between keycode decode/player logic and the ball-collision and colour-mapper blocks.
- Clocked on frame_clk; bullet_on is combinational on DrawX/DrawY for the pixel pipeline.

---
 rtl/harpoon_bank.sv | 171 +++++++++++++++++
 tb/tb_harpoon_bank.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/harpoon_bank.sv
// harpoon_bank: multi-slot harpoon controller for one player.
// Fire edge launch, double/sticky modes, per-slot hit and pixel test.
module harpoon_bank #(
  parameter int NUM_SHOTS    = 2,
  parameter int SPEED        = 5,
  parameter int Y_MIN        = 0,
  parameter int X_OFFSET     = 20,
  parameter int STICK_FRAMES = 60,
  parameter int FLOOR_Y      = 398
) (
  input  logic                   frame_clk,
  input  logic                   Reset,
  input  logic [1:0]             game_on,
  input  logic                   fire,
  input  logic [1:0]             mode,
  input  logic                   freeze,
  input  logic                   inplay,
  input  logic [9:0]             PlayerX,
  input  logic [9:0]             PlayerY,
  input  logic [NUM_SHOTS-1:0]   hit,
  input  logic [9:0]             DrawX,
  input  logic [9:0]             DrawY,
  output logic [10*NUM_SHOTS-1:0] BulletX,
  output logic [10*NUM_SHOTS-1:0] BulletY,
  output logic [NUM_SHOTS-1:0]   active,
  output logic                   shot_fired,
  output logic                   bullet_on
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RISE  = 2'd1,
    STUCK = 2'd2
  } state_t;

  localparam int CW = $clog2(STICK_FRAMES + 1);
  localparam logic [CW-1:0] STICK_INIT = CW'(STICK_FRAMES - 1);
  localparam logic [9:0] Y_TH  = 10'(Y_MIN + SPEED);
  localparam logic [9:0] Y_LO  = 10'(Y_MIN);
  localparam logic [9:0] SPD   = 10'(SPEED);
  localparam logic [9:0] X_OFS = 10'(X_OFFSET);
  localparam logic [9:0] FLOOR = 10'(FLOOR_Y);

  logic                 run;
  logic                 fire_prev_q, fire_prev_d;
  logic                 shot_q, shot_d;
  logic                 fire_edge;
  logic                 launch;
  logic [NUM_SHOTS-1:0] idle;
  logic [NUM_SHOTS-1:0] sel;
  logic [NUM_SHOTS-1:0] on;
  logic [2:0]           n_act;
  logic [2:0]           limit;

  assign run       = (game_on == 2'd1);
  assign fire_edge = fire & ~fire_prev_q;

  // Launch arbitration: lowest idle slot, gated by mode-dependent limit.
  always_comb begin
    n_act = 3'd0;
    for (int k = 0; k < NUM_SHOTS; k++) begin
      if (!idle[k]) n_act = n_act + 3'd1;
    end
    limit = 3'd1;
    if (mode == 2'd1 || mode == 2'd2) limit = 3'(NUM_SHOTS);
    sel         = idle & (~idle + 1'b1);
    launch      = run & ~freeze & fire_edge & (|idle) & (n_act < limit);
    shot_d      = launch;
    fire_prev_d = fire;
  end

  // Edge detector and launch pulse registers.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      fire_prev_q <= 1'b1;
      shot_q      <= 1'b0;
    end else begin
      fire_prev_q <= fire_prev_d;
      shot_q      <= shot_d;
    end
  end

  for (genvar i = 0; i < NUM_SHOTS; i++) begin : g_slot
    state_t          st_q, st_d;
    logic [9:0]      x_q, x_d;
    logic [9:0]      y_q, y_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sticky_q, sticky_d;

    // Slot next-state: track player when idle, rise, stick, launch.
    always_comb begin
      st_d     = st_q;
      x_d      = x_q;
      y_d      = y_q;
      cnt_d    = cnt_q;
      sticky_d = sticky_q;
      if (!run) begin
        st_d = IDLE;
        x_d  = PlayerX;
        y_d  = PlayerY;
      end else if (!freeze) begin
        unique case (st_q)
          IDLE: begin
            x_d = PlayerX;
            y_d = PlayerY;
          end
          RISE: begin
            if (hit[i]) begin
              st_d = IDLE;
            end else if (y_q > Y_TH) begin
              y_d = y_q - SPD;
            end else begin
              y_d = Y_LO;
              if (sticky_q) begin
                st_d  = STUCK;
                cnt_d = STICK_INIT;
              end else begin
                st_d = IDLE;
              end
            end
          end
          STUCK: begin
            y_d = Y_LO;
            if (hit[i]) begin
              st_d = IDLE;
            end else if (cnt_q == '0) begin
              st_d = IDLE;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
          default: st_d = IDLE;
        endcase
        if (launch && sel[i]) begin
          st_d     = RISE;
          x_d      = PlayerX + X_OFS;
          y_d      = PlayerY;
          sticky_d = (mode == 2'd2);
        end
      end
    end

    // Slot state registers.
    always_ff @(posedge frame_clk) begin
      if (Reset) begin
        st_q     <= IDLE;
        x_q      <= '0;
        y_q      <= '0;
        cnt_q    <= '0;
        sticky_q <= 1'b0;
      end else begin
        st_q     <= st_d;
        x_q      <= x_d;
        y_q      <= y_d;
        cnt_q    <= cnt_d;
        sticky_q <= sticky_d;
      end
    end

    assign idle[i]          = (st_q == IDLE);
    assign active[i]        = ~idle[i];
    assign BulletX[10*i+:10] = x_q;
    assign BulletY[10*i+:10] = y_q;
    assign on[i] = active[i] & (DrawX == x_q) &
                   (DrawY > y_q) & (DrawY < FLOOR);
  end

  assign shot_fired = shot_q;
  assign bullet_on  = inplay & ~freeze & (|on);

endmodule

// File: tb/tb_harpoon_bank.sv
// tb_harpoon_bank: directed vectors for harpoon_bank.
// Two slots, four-frame sticky hold.
module tb_harpoon_bank;
  logic        frame_clk = 1'b0;
  logic        Reset;
  logic [1:0]  game_on;
  logic        fire;
  logic [1:0]  mode;
  logic        freeze;
  logic        inplay;
  logic [9:0]  PlayerX, PlayerY;
  logic [1:0]  hit;
  logic [9:0]  DrawX, DrawY;
  logic [19:0] BulletX, BulletY;
  logic [1:0]  active;
  logic        shot_fired;
  logic        bullet_on;

  int nvec = 0;
  int nerr = 0;

  harpoon_bank #(
    .NUM_SHOTS(2), .SPEED(5), .Y_MIN(0), .X_OFFSET(20),
    .STICK_FRAMES(4), .FLOOR_Y(398)
  ) dut (
    .frame_clk(frame_clk), .Reset(Reset), .game_on(game_on),
    .fire(fire), .mode(mode), .freeze(freeze), .inplay(inplay),
    .PlayerX(PlayerX), .PlayerY(PlayerY), .hit(hit),
    .DrawX(DrawX), .DrawY(DrawY), .BulletX(BulletX),
    .BulletY(BulletY), .active(active),
    .shot_fired(shot_fired), .bullet_on(bullet_on)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge frame_clk);
    #1;
  endtask

  initial begin
    Reset = 1; game_on = 2'd1; fire = 1; mode = 2'd0;
    freeze = 0; inplay = 1; PlayerX = 10'd100; PlayerY = 10'd380;
    hit = 2'b00; DrawX = 10'd0; DrawY = 10'd0;
    step(); step();
    check("rst_active", 32'(active), 32'd0);
    check("rst_shot", 32'(shot_fired), 32'd0);
    check("rst_x", 32'(BulletX), 32'd0);
    check("rst_y", 32'(BulletY), 32'd0);

    Reset = 0;
    step(); step(); step();
    check("held_active", 32'(active), 32'd0);
    check("held_shot", 32'(shot_fired), 32'd0);
    check("idle_y0", 32'(BulletY[9:0]), 32'd380);

    fire = 0; step();
    fire = 1; step();
    check("l0_active", 32'(active), 32'd1);
    check("l0_shot", 32'(shot_fired), 32'd1);
    check("l0_x", 32'(BulletX[9:0]), 32'd120);
    check("l0_y", 32'(BulletY[9:0]), 32'd380);
    fire = 0; step();
    check("l0_pulse", 32'(shot_fired), 32'd0);
    check("l0_y1", 32'(BulletY[9:0]), 32'd375);
    for (int f = 2; f <= 76; f++) begin
      if (f == 10) fire = 1;
      if (f == 12) fire = 0;
      step();
      if (f == 10) begin
        check("m0_ign_shot", 32'(shot_fired), 32'd0);
        check("m0_ign_act", 32'(active), 32'd1);
      end
      if (f == 38) check("m0_y38", 32'(BulletY[9:0]), 32'd190);
      if (f == 75) begin
        check("m0_y75", 32'(BulletY[9:0]), 32'd5);
        check("m0_act75", 32'(active), 32'd1);
      end
      if (f == 76) begin
        check("m0_y76", 32'(BulletY[9:0]), 32'd0);
        check("m0_act76", 32'(active), 32'd0);
        check("m0_x1idle", 32'(BulletX[19:10]), 32'd100);
      end
    end

    mode = 2'd1; fire = 1; step();
    check("m1_a", 32'(active), 32'd1);
    fire = 0; step(); step(); step();
    fire = 1; step();
    check("m1_both", 32'(active), 32'd3);
    check("m1_shot", 32'(shot_fired), 32'd1);
    check("m1_x1", 32'(BulletX[19:10]), 32'd120);
    check("m1_y1", 32'(BulletY[19:10]), 32'd380);
    check("m1_y0", 32'(BulletY[9:0]), 32'd360);
    fire = 0; step();
    fire = 1; step();
    check("m1_third", 32'(active), 32'd3);
    check("m1_third_shot", 32'(shot_fired), 32'd0);
    fire = 0; hit = 2'b01; step();
    hit = 2'b00;
    check("m1_hit", 32'(active), 32'd2);
    check("m1_y1_hit", 32'(BulletY[19:10]), 32'd365);

    game_on = 2'd0; step();
    check("go_active", 32'(active), 32'd0);
    check("go_x0", 32'(BulletX[9:0]), 32'd100);
    check("go_y1", 32'(BulletY[19:10]), 32'd380);
    game_on = 2'd1;

    mode = 2'd2; fire = 1; step();
    check("st_launch", 32'(active), 32'd1);
    fire = 0; mode = 2'd0;
    for (int f = 1; f <= 76; f++) step();
    check("st_y0", 32'(BulletY[9:0]), 32'd0);
    check("st_stuck", 32'(active), 32'd1);
    step(); step(); step();
    check("st_hold", 32'(active), 32'd1);
    check("st_hold_y", 32'(BulletY[9:0]), 32'd0);
    step();
    check("st_done", 32'(active), 32'd0);

    mode = 2'd2; fire = 1; step();
    fire = 0;
    for (int f = 1; f <= 76; f++) step();
    check("sh_stuck", 32'(active), 32'd1);
    hit = 2'b01; step();
    hit = 2'b00;
    check("sh_hit", 32'(active), 32'd0);

    mode = 2'd1; fire = 1; step();
    fire = 0;
    for (int f = 1; f <= 36; f++) step();
    check("fz_y", 32'(BulletY[9:0]), 32'd200);
    freeze = 1; DrawX = 10'd120; DrawY = 10'd250;
    fire = 1; step();
    fire = 0; step();
    fire = 1; step();
    step();
    fire = 0; step();
    check("fz_hold_y", 32'(BulletY[9:0]), 32'd200);
    check("fz_active", 32'(active), 32'd1);
    check("fz_shot", 32'(shot_fired), 32'd0);
    check("fz_draw", 32'(bullet_on), 32'd0);
    freeze = 0; #1;
    check("fz_draw_on", 32'(bullet_on), 32'd1);
    step();
    check("fz_resume", 32'(BulletY[9:0]), 32'd195);
    check("fz_act2", 32'(active), 32'd1);

    game_on = 2'd0; step();
    game_on = 2'd1; mode = 2'd0; PlayerY = 10'd300;
    fire = 1; step();
    check("px_x", 32'(BulletX[9:0]), 32'd120);
    check("px_y", 32'(BulletY[9:0]), 32'd300);
    DrawX = 10'd120; DrawY = 10'd301; #1;
    check("px_on", 32'(bullet_on), 32'd1);
    DrawY = 10'd300; #1;
    check("px_top", 32'(bullet_on), 32'd0);
    DrawY = 10'd398; #1;
    check("px_floor", 32'(bullet_on), 32'd0);
    DrawX = 10'd121; DrawY = 10'd301; #1;
    check("px_x121", 32'(bullet_on), 32'd0);
    DrawX = 10'd120; inplay = 0; #1;
    check("px_inplay", 32'(bullet_on), 32'd0);
    inplay = 1;

    game_on = 2'd0; step();
    game_on = 2'd1; mode = 2'd1; PlayerY = 10'd380;
    fire = 0; step();
    fire = 1; step();
    fire = 0; step();
    fire = 1; step();
    check("md_two", 32'(active), 32'd3);
    mode = 2'd0; fire = 0; hit = 2'b01; step();
    hit = 2'b00;
    check("md_hit", 32'(active), 32'd2);
    fire = 1; step();
    check("md_block", 32'(active), 32'd2);
    check("md_block_shot", 32'(shot_fired), 32'd0);
    mode = 2'd1; fire = 0; step();
    fire = 1; step();
    check("fr_two", 32'(active), 32'd3);
    fire = 0; step();
    fire = 1; hit = 2'b01; step();
    hit = 2'b00;
    check("fr_noelig", 32'(active), 32'd2);
    check("fr_noshot", 32'(shot_fired), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
